// File: rtl/muldiv_ctrl.sv
// Multi-cycle radix-2 multiply/divide sequencer owning HI/LO; stalls the datapath while busy.
// Optional MULDIV_FWD_EN: forward the corrected result on hi/lo during FIXUP so mfhi/mflo need not stall there.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             rd_hi,
  input  logic             rd_lo,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] opnd;      // multiplicand (mult) or divisor (div)
  logic [WIDTH-1:0] acc;       // product high half / partial remainder
  logic [WIDTH-1:0] shf;       // multiplier bits / dividend-then-quotient
  logic [WIDTH-1:0] srca_raw;
  logic             is_div, is_signed, neg_a, neg_b, b_zero;

  logic             in_signed;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   dshift;
  logic [WIDTH+1:0] ddiff;
  logic             borrow;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  logic             rd_stall;

  assign in_signed = ~op[0];
  assign a_abs = (in_signed & srca[WIDTH-1]) ? -srca : srca;
  assign b_abs = (in_signed & srcb[WIDTH-1]) ? -srcb : srcb;

  // One shift-add step: add multiplicand when the current multiplier LSB is set, then shift right.
  assign msum = {1'b0, acc} + (shf[0] ? {1'b0, opnd} : '0);

  // One restoring-division step on the remainder with the next dividend bit shifted in.
  assign dshift = {acc, shf[WIDTH-1]};
  assign ddiff  = {1'b0, dshift} - {2'b00, opnd};
  assign borrow = ddiff[WIDTH+1];

  assign prod = {acc, shf};

  always_comb begin
    fix_hi = '0;
    fix_lo = '0;
    if (!is_div) begin
      if (is_signed & (neg_a ^ neg_b)) begin
        {fix_hi, fix_lo} = -prod;
      end else begin
        {fix_hi, fix_lo} = prod;
      end
    end else if (b_zero) begin
      fix_lo = '1;
      fix_hi = srca_raw;
    end else begin
      fix_lo = (is_signed & (neg_a ^ neg_b)) ? -shf : shf;
      fix_hi = (is_signed & neg_a) ? -acc : acc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (op_valid) state_nxt = RUN;
      RUN:     if (count == '0) state_nxt = FIXUP;
      FIXUP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd      <= '0;
      acc       <= '0;
      shf       <= '0;
      srca_raw  <= '0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      b_zero    <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done     <= (state == FIXUP);
      div_zero <= (state == FIXUP) & is_div & b_zero;
      case (state)
        IDLE: begin
          if (op_valid) begin
            is_div    <= op[1];
            is_signed <= in_signed;
            neg_a     <= in_signed & srca[WIDTH-1];
            neg_b     <= in_signed & srcb[WIDTH-1];
            b_zero    <= (srcb == '0);
            srca_raw  <= srca;
            acc       <= '0;
            opnd      <= op[1] ? b_abs : a_abs;
            shf       <= op[1] ? a_abs : b_abs;
            count     <= CW'(WIDTH - 1);
          end else begin
            if (mthi) hi_q <= srca;
            if (mtlo) lo_q <= srca;
          end
        end
        RUN: begin
          if (is_div) begin
            acc <= borrow ? dshift[WIDTH-1:0] : ddiff[WIDTH-1:0];
            shf <= {shf[WIDTH-2:0], ~borrow};
          end else begin
            acc <= msum[WIDTH:1];
            shf <= {msum[0], shf[WIDTH-1:1]};
          end
          if (count != '0) count <= count - CW'(1);
        end
        FIXUP: begin
          hi_q <= fix_hi;
          lo_q <= fix_lo;
        end
        default: ;
      endcase
    end
  end

`ifdef MULDIV_FWD_EN
  assign hi       = (state == FIXUP) ? fix_hi : hi_q;
  assign lo       = (state == FIXUP) ? fix_lo : lo_q;
  assign rd_stall = (rd_hi | rd_lo) & (state != FIXUP);
`else
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign rd_stall = rd_hi | rd_lo;
`endif

  assign busy  = (state != IDLE);
  assign stall = busy & (op_valid | mthi | mtlo | rd_stall);

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer that owns the HI/LO special registers.
- Accepts mult/multu/div/divu ops from the decoder, latches operands, and runs a radix-2 shift-add/shift-subtract engine for WIDTH cycles. It then sign-corrects the result and commits it to HI/LO.
- Stalls the single-cycle datapath (PC and register write) when an instruction needs HI/LO or the engine while a computation is in flight.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op_valid  in  1  decoder issues a mul/div op this cycle.
- op  in  2  00 mult, 01 multu, 10 div, 11 divu.
- srca  in  WIDTH  rs operand: multiplicand/dividend; also the mthi/mtlo data.
- srcb  in  WIDTH  rt operand: multiplier/divisor.
- mthi  in  1  write srca to HI.
- mtlo  in  1  write srca to LO.
- rd_hi  in  1  current instruction is mfhi.
- rd_lo  in  1  current instruction is mflo.
- stall  out  1  freeze PC and suppress regwrite/spregwrite this cycle.
- busy  out  1  engine not IDLE.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- done  out  1  one-cycle pulse after HI/LO commit.
- div_zero  out  1  pulses with done when a div/divu had srcb==0.

Behaviour:
- Reset (async, any state): state=IDLE, hi=0, lo=0, done=0, div_zero=0, counter=0; stall and busy fall immediately; any in-flight op is discarded.
- States:
  - IDLE: on op_valid at edge E0, latch |srca| and |srcb| (absolute values for signed ops; raw values for unsigned), latch the sign flags and op, clear the partial accumulator, load counter=WIDTH-1, go to RUN.
  - RUN: one iteration per edge. Multiply is shift-add on a 2*WIDTH product. Divide is restoring shift-subtract producing quotient and remainder. At counter==0, go to FIXUP; otherwise decrement.
  - FIXUP: apply sign correction, write hi/lo, go to IDLE; done=1 for the next cycle.
- Latency: HI/LO hold the new result after edge E0+WIDTH+1 (E0+33 for WIDTH=32); done is high during the cycle following that edge.
- Sign rules:
  - Signed product is negated if the operand signs differ.
  - Signed quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - Unsigned ops use no correction.
- Divide by zero: no trap. lo=all ones, hi=srca (original, uncorrected). Same latency as a normal divide. div_zero=1 together with done.
- Signed overflow (min-int / -1): lo=min-int, hi=0, div_zero=0.
- stall = busy & (op_valid | rd_hi | rd_lo | mthi | mtlo). This is combinational from inputs and state.
- An op_valid arriving while busy is not accepted; it is held by the stall and accepted at the first edge where state==IDLE.
- mthi/mtlo in IDLE write srca at the edge.
- mthi and mtlo together write both registers.
- op_valid together with mthi/mtlo in IDLE: op_valid wins and mthi/mtlo are ignored (illegal decode).
- hi/lo outputs are registers. Reads in IDLE return the committed values with no stall.
- Back-to-back ops: a new op may be accepted in the IDLE cycle immediately after FIXUP, i.e. the same cycle done is high.

Optional Feature:
- Macro: MULDIV_FWD_EN.
- Defined: during FIXUP, the hi/lo outputs present the corrected result combinationally. rd_hi/rd_lo do not assert stall in FIXUP, saving one stall cycle for mfhi/mflo. op_valid/mthi/mtlo still stall in FIXUP.
- Undefined: hi/lo are pure register outputs and stall holds through FIXUP.

Test Plan:
1. multu srca=0xFFFFFFFF srcb=0xFFFFFFFF -> after E0+33: hi=0xFFFFFFFE, lo=0x00000001; done high for one cycle; busy high for 33 cycles.
2. mult srca=-7 (0xFFFFFFF9) srcb=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
3. divu 100/7 -> lo=14, hi=2. div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
4. divu srca=0x1234 srcb=0 -> lo=0xFFFFFFFF, hi=0x1234, div_zero=1 coincident with done; div_zero low on the next op.
5. rd_lo held high from E0+1 -> stall=1 through E0+33 (through E0+32 with MULDIV_FWD_EN), and lo reads the new value when stall drops. A second op_valid during RUN is accepted only after the first completes.
6. reset pulsed mid-RUN (10 cycles after E0) -> stall, busy, hi, lo immediately 0, with no done pulse. A following mtlo 0x55 then mflo returns 0x55 with no stall.
